// File: rtl/tug_referee.sv
// ---------------------------------------------------------------------------
// tug_referee
//
// Match controller for the nine-light tug-of-war play field.
//
// The referee sits between the two player keys and the play field:
//   - It turns key levels into single-cycle L/R move pulses. A held key gives
//     exactly one pulse. Presses that land in the same cycle cancel each other.
//   - It watches the two end lights. A point is scored when a player presses
//     while the light is on their own end.
//   - It keeps both scores and holds the field in reset between points.
//   - It declares the winner and then freezes until Reset.
//
// Compile-time option:
//   TUG_HOLDOFF_EN - when defined, the field-reset phase after a point lasts
//                    HOLDOFF cycles instead of one. A down-counter times it,
//                    and the win check runs on the last cycle of that phase.
//                    When undefined, no counter logic is generated.
//
// Parameters:
//   WIN_SCORE - points needed to win (1 .. 2**SCORE_W-1)
//   SCORE_W   - width of each score counter
//   HOLDOFF   - field-reset hold cycles after a point (TUG_HOLDOFF_EN only)
//
// Ports:
//   Clock       in   system clock
//   Reset       in   synchronous active-high reset
//   keyL, keyR  in   player key levels, already synchronized
//   leftEnd     in   leftmost field light
//   rightEnd    in   rightmost field light
//   fieldReset  out  reset to the play field (high whenever not in play)
//   L, R        out  registered single-cycle move pulses to the field
//   scoreL/R    out  per-player scores
//   matchWinner out  2'b00 none, 2'b10 left, 2'b01 right
// ---------------------------------------------------------------------------
module tug_referee #(
    parameter int WIN_SCORE = 7,
    parameter int SCORE_W   = 3,
    parameter int HOLDOFF   = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               keyL,
    input  logic               keyR,
    input  logic               leftEnd,
    input  logic               rightEnd,
    output logic               fieldReset,
    output logic               L,
    output logic               R,
    output logic [SCORE_W-1:0] scoreL,
    output logic [SCORE_W-1:0] scoreR,
    output logic [1:0]         matchWinner
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    // Elaboration stops here if a parameter is outside its legal range.
    if (HOLDOFF < 1 || WIN_SCORE < 1 || WIN_SCORE >= (2 ** SCORE_W)) begin : g_param_check
        tug_referee_illegal_parameter u_param_check ();
    end

    typedef enum logic [1:0] {
        RST_FIELD,
        PLAY,
        SCORED,
        DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Per-side vectors: bit 1 is the left player, bit 0 is the right player.
    logic [1:0] key_vec;
    logic [1:0] end_vec;
    logic [1:0] key_dly_reg;
    logic [1:0] pulse;
    logic [1:0] valid;
    logic [1:0] hit;
    logic [1:0] move;

    logic [SCORE_W-1:0] score_l_reg;
    logic [SCORE_W-1:0] score_l_next;
    logic [SCORE_W-1:0] score_r_reg;
    logic [SCORE_W-1:0] score_r_next;
    logic [1:0]         winner_reg;
    logic [1:0]         winner_next;
    logic [1:0]         move_reg;
    logic [1:0]         move_next;

    // High on the cycle that SCORED hands over to PLAY or DONE.
    logic               scored_last;

    assign key_vec = {keyL, keyR};
    assign end_vec = {leftEnd, rightEnd};

    // The edge registers keep tracking the keys in every state. Because of
    // this, a key held through a point or a field reset does not produce a
    // late pulse when play resumes.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            key_dly_reg <= 2'b00;
        end else begin
            key_dly_reg <= key_vec;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        assign pulse[gi] = key_vec[gi] & ~key_dly_reg[gi];
        // A pulse counts only when the other player did not press in the
        // same cycle.
        assign valid[gi] = pulse[gi] & ~pulse[1 - gi];
        // Each side looks only at its own end light. If both lights are on
        // (an illegal field state), only the side that pressed scores.
        assign hit[gi]   = valid[gi] & end_vec[gi];
        assign move[gi]  = valid[gi] & ~end_vec[gi];
    end

`ifdef TUG_HOLDOFF_EN
    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 1);

    logic [HOLD_W-1:0] hold_cnt_reg;
    logic [HOLD_W-1:0] hold_cnt_next;

    // The counter is loaded with HOLDOFF-1 when a point is scored. SCORED
    // therefore covers the counts HOLDOFF-1 down to 0, which is HOLDOFF
    // cycles in total.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hold_cnt_reg <= '0;
        end else begin
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        hold_cnt_next = hold_cnt_reg;
        if (state_reg == PLAY && hit != 2'b00) begin
            hold_cnt_next = HOLD_LOAD;
        end else if (state_reg == SCORED && hold_cnt_reg != '0) begin
            hold_cnt_next = hold_cnt_reg - 1'b1;
        end
    end

    assign scored_last = (hold_cnt_reg == '0);
`else
    assign scored_last = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg   <= RST_FIELD;
            score_l_reg <= '0;
            score_r_reg <= '0;
            winner_reg  <= 2'b00;
            move_reg    <= 2'b00;
        end else begin
            state_reg   <= state_next;
            score_l_reg <= score_l_next;
            score_r_reg <= score_r_next;
            winner_reg  <= winner_next;
            move_reg    <= move_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        score_l_next = score_l_reg;
        score_r_next = score_r_reg;
        winner_next  = winner_reg;
        move_next    = 2'b00;

        case (state_reg)
            RST_FIELD: begin
                state_next = PLAY;
            end

            PLAY: begin
                if (hit[1]) begin
                    score_l_next = score_l_reg + 1'b1;
                    state_next   = SCORED;
                end else if (hit[0]) begin
                    score_r_next = score_r_reg + 1'b1;
                    state_next   = SCORED;
                end else begin
                    move_next = move;
                end
            end

            SCORED: begin
                if (scored_last) begin
                    // Scores stop at WIN_SCORE because reaching it always
                    // ends the match here. This means the counters never
                    // wrap.
                    if (score_l_reg == WIN_VAL) begin
                        winner_next = 2'b10;
                        state_next  = DONE;
                    end else if (score_r_reg == WIN_VAL) begin
                        winner_next = 2'b01;
                        state_next  = DONE;
                    end else begin
                        state_next = PLAY;
                    end
                end
            end

            DONE: begin
                state_next = DONE;
            end

            default: begin
                state_next = RST_FIELD;
            end
        endcase
    end

    assign fieldReset  = (state_reg != PLAY);
    assign L           = move_reg[1];
    assign R           = move_reg[0];
    assign scoreL      = score_l_reg;
    assign scoreR      = score_r_reg;
    assign matchWinner = winner_reg;

endmodule

// File: tb/tb_tug_referee.sv
module tb_tug_referee;

    localparam int WIN  = 7;
    localparam int SW   = 3;
    localparam int HOLD = 4;
`ifdef TUG_HOLDOFF_EN
    localparam int SCORED_LEN = HOLD;
`else
    localparam int SCORED_LEN = 1;
`endif

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          keyL = 1'b0;
    logic          keyR = 1'b0;
    logic          leftEnd = 1'b0;
    logic          rightEnd = 1'b0;
    logic          fieldReset;
    logic          L;
    logic          R;
    logic [SW-1:0] scoreL;
    logic [SW-1:0] scoreR;
    logic [1:0]    matchWinner;

    always #5 Clock = ~Clock;

    tug_referee #(
        .WIN_SCORE(WIN),
        .SCORE_W  (SW),
        .HOLDOFF  (HOLD)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .keyL       (keyL),
        .keyR       (keyR),
        .leftEnd    (leftEnd),
        .rightEnd   (rightEnd),
        .fieldReset (fieldReset),
        .L          (L),
        .R          (R),
        .scoreL     (scoreL),
        .scoreR     (scoreR),
        .matchWinner(matchWinner)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. Match progress is tracked as points and a countdown
    // of field-reset cycles, not as controller states.
    bit m_prev_l, m_prev_r;
    int m_score_l, m_score_r;
    int m_winner;       // 0 none, 2 left, 1 right
    int m_wait;         // field-reset cycles still to go before play
    bit m_point_due;    // the current wait follows a point: win check at its end
    bit m_over;
    bit m_l, m_r;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit kl, input bit kr, input bit le, input bit re);
        bit pl, pr;
        pl = kl & ~m_prev_l;
        pr = kr & ~m_prev_r;
        m_l = 1'b0;
        m_r = 1'b0;
        if (rst) begin
            m_score_l   = 0;
            m_score_r   = 0;
            m_winner    = 0;
            m_wait      = 1;
            m_point_due = 1'b0;
            m_over      = 1'b0;
            pl = 1'b0;
            pr = 1'b0;
            kl = 1'b0;
            kr = 1'b0;
        end else if (m_over) begin
            // match finished: everything frozen
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0 && m_point_due) begin
                m_point_due = 1'b0;
                if (m_score_l == WIN) begin
                    m_winner = 2;
                    m_over   = 1'b1;
                    $display("match won by left %0d-%0d", m_score_l, m_score_r);
                end else if (m_score_r == WIN) begin
                    m_winner = 1;
                    m_over   = 1'b1;
                    $display("match won by right %0d-%0d", m_score_l, m_score_r);
                end
            end
        end else if (pl != pr) begin
            if (pl && le) begin
                m_score_l++;
                m_wait = SCORED_LEN;
                m_point_due = 1'b1;
                $display("point left -> %0d-%0d", m_score_l, m_score_r);
            end else if (pr && re) begin
                m_score_r++;
                m_wait = SCORED_LEN;
                m_point_due = 1'b1;
                $display("point right -> %0d-%0d", m_score_l, m_score_r);
            end else begin
                m_l = pl;
                m_r = pr;
            end
        end
        m_prev_l = kl;
        m_prev_r = kr;
    endtask

    // One clock cycle: drive the inputs on the falling edge, advance the
    // model at the rising edge, and compare shortly after that edge.
    task automatic cycle(input bit rst, input bit kl, input bit kr, input bit le, input bit re);
        @(negedge Clock);
        Reset    = rst;
        keyL     = kl;
        keyR     = kr;
        leftEnd  = le;
        rightEnd = re;
        @(posedge Clock);
        model_step(rst, kl, kr, le, re);
        #1;
        check_val("fieldReset", 32'(fieldReset), 32'(m_over || m_wait > 0));
        check_val("L", 32'(L), 32'(m_l));
        check_val("R", 32'(R), 32'(m_r));
        check_val("scoreL", 32'(scoreL), 32'(m_score_l));
        check_val("scoreR", 32'(scoreR), 32'(m_score_r));
        check_val("matchWinner", 32'(matchWinner), 32'(m_winner));
    endtask

    initial begin
        bit kl, kr, le, re, rst;

        // Reset, then let the controller idle.
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // A held left key must give exactly one L pulse.
        repeat (5) cycle(0, 1, 0, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);

        // Simultaneous presses cancel each other.
        repeat (2) cycle(0, 1, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // Seven left points. The fourth one has both end lights on.
        for (int p = 0; p < WIN; p++) begin
            cycle(0, 1, 0, 1, (p == 3));
            repeat (SCORED_LEN + 2) cycle(0, 0, 0, 0, 0);
        end
        // The match is over: keys and lights must have no effect.
        for (int i = 0; i < 12; i++) begin
            cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Score three right points, then assert Reset while the third point
        // is still in its field-reset phase.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            cycle(0, 0, 1, 0, 1);
            repeat (SCORED_LEN + 2) cycle(0, 0, 0, 0, 0);
        end
        cycle(0, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);

        // Random play with occasional resets.
        kl = 1'b0;
        kr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 2) == 0) kl = ~kl;
            if ($urandom_range(0, 2) == 0) kr = ~kr;
            le = ($urandom_range(0, 3) == 0);
            re = ($urandom_range(0, 3) == 0);
            cycle(rst, kl, kr, le, re);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_referee.md
Name: tug_referee

Overview:
- Match controller for the nine-light tug-of-war play field.
- Converts player key levels into single-cycle L/R move pulses and cancels simultaneous presses.
- Detects points from the field end lights, keeps per-player scores, resets the field between points and declares the match winner.
- Sits between the key inputs and the play field: drives the field's Reset, L and R; reads its two end lights.

Parameters:
WIN_SCORE, 7, points needed to win the match (1..2^SCORE_W-1)
SCORE_W, 3, width of each score counter
HOLDOFF, 4, field-reset hold cycles after a point (only with TUG_HOLDOFF_EN)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous active-high reset
keyL  in  1  left-player key level, already synchronized
keyR  in  1  right-player key level, already synchronized
leftEnd  in  1  field leftmost light (lights[9])
rightEnd  in  1  field rightmost light (lights[1])
fieldReset  out  1  reset to play field
L  out  1  left move pulse to field
R  out  1  right move pulse to field
scoreL  out  SCORE_W  left-player score
scoreR  out  SCORE_W  right-player score
matchWinner  out  2  00 none, 10 left, 01 right

Behaviour:
- One clock; reset is synchronous and active-high; all state changes on posedge Clock.
- Edge detect:
  - kLd/kRd register previous key levels; reset value 0.
  - pL = keyL & ~kLd, pR = keyR & ~kRd; these run in every state.
  - A held key yields exactly one pulse.
- Arbitration:
  - pL & pR in the same cycle: both dropped, no move, no point.
  - Exactly one pulse is "valid".
- States: RST_FIELD, PLAY, SCORED, DONE. Reset forces RST_FIELD, scoreL=scoreR=0, matchWinner=00, L=R=0, kLd=kRd=0.
- fieldReset:
  - Moore output, 1 in RST_FIELD, SCORED and DONE; 0 in PLAY.
  - First cycle after Reset deasserts: fieldReset=1.
- RST_FIELD: one cycle, then PLAY.
- PLAY:
  - Valid pL with leftEnd=1: left point. scoreL+1, go to SCORED, no L pulse.
  - Valid pR with rightEnd=1: right point. scoreR+1, go to SCORED, no R pulse.
  - Any other valid pL/pR: L/R registered high for exactly one cycle (1-cycle latency from the key edge).
  - Otherwise L=R=0.
- SCORED:
  - L=R=0; key edges ignored (edge registers still update).
  - If either score equals WIN_SCORE: matchWinner set in the same transition, go to DONE. Else go to PLAY.
- DONE:
  - Absorbing: fieldReset=1, L=R=0, scores and matchWinner frozen until Reset.
- Score arithmetic:
  - Unsigned, never exceeds WIN_SCORE, no wrap.
  - Increments only on a PLAY→SCORED transition.
- Reset mid-point (any state): immediate return to reset values next edge; pending pulses discarded.
- leftEnd and rightEnd both 1 (illegal field state): a point is awarded only for the side whose key pulsed.

Optional Feature:
- Macro TUG_HOLDOFF_EN.
- Defined:
  - SCORED lasts HOLDOFF cycles, counted by a down-counter loaded on entry; fieldReset held high throughout; key edges ignored.
  - The win check happens on the final SCORED cycle.
- Undefined: SCORED lasts exactly one cycle; no counter logic is generated.

Test Plan:
- Reset 1 cycle, then idle → fieldReset=1 for 1 cycle, then 0; scores 0/0, matchWinner=00, L=R=0.
- keyL held high 5 cycles from PLAY → exactly one L pulse, one cycle after the rising edge; no further L.
- keyL and keyR rise same cycle → L=R=0, scores unchanged, state stays PLAY.
- leftEnd=1, keyL rising edge → scoreL 0→1, no L pulse, fieldReset=1 for 1 cycle (HOLDOFF=4 cycles with TUG_HOLDOFF_EN), then PLAY.
- Seven left points with WIN_SCORE=7 → scoreL=7, matchWinner=10, fieldReset stuck 1, further keys give no L/R and no score change until Reset.
- Reset asserted during SCORED at scoreR=3 → next cycle scoreR=0, state RST_FIELD, fieldReset=1.
